// File: rtl/mult_pkg.sv
// Shared types and sizing for the sequential shift-and-add multiplier.
// No logic; constants only.
package mult_pkg;
    localparam int OPW  = 4;
    localparam int ITER = 4;
    localparam int PW   = 2 * OPW;
    localparam int CNTW = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mult_4b_seq_if.sv
// Request/result bundle between a requester and mult_4b_seq.
// No flow control beyond start/busy: requests while busy are dropped.
interface mult_4b_seq_if;
    import mult_pkg::*;

    logic            start;
    logic [OPW-1:0]  A;
    logic [OPW-1:0]  B;
    logic [PW-1:0]   P;
    logic            busy;
    logic            done;

    modport master (output start, A, B, input P, busy, done);
    modport slave  (input start, A, B, output P, busy, done);
endinterface

// File: rtl/adder_4b.sv
// Combinational 4-bit ripple-carry adder; zero latency, no backpressure.
// Cout is the carry out of the top bit.
module adder_4b
    import mult_pkg::*;
(
    input  logic [OPW-1:0] A,
    input  logic [OPW-1:0] B,
    input  logic           Cin,
    output logic [OPW-1:0] S,
    output logic           Cout
);
    logic [OPW:0] w_carry;

    assign w_carry[0] = Cin;

    for (genvar i = 0; i < OPW; i++) begin : g_fa
        assign S[i]           = A[i] ^ B[i] ^ w_carry[i];
        assign w_carry[i + 1] = (A[i] & B[i]) | (w_carry[i] & (A[i] ^ B[i]));
    end

    assign Cout = w_carry[OPW];
endmodule

// File: rtl/mult_4b_seq.sv
// 4x4 unsigned shift-and-add multiplier; done strobes 4 cycles after start is sampled.
// Busy for 5 cycles per operation; start while busy is dropped, never queued.
module mult_4b_seq
    import mult_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mult_4b_seq_if.slave  bus
);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(ITER - 1);

    state_t          r_state;
    logic [OPW-1:0]  r_m;
    logic [OPW-1:0]  r_acc;
    logic [OPW-1:0]  r_q;
    logic [CNTW-1:0] r_cnt;
    logic [PW-1:0]   r_p;
    logic            r_busy;
    logic            r_done;

    logic [OPW-1:0]  w_y;
    logic [OPW-1:0]  w_s;
    logic            w_c;
    logic [OPW-1:0]  w_acc_nxt;
    logic [OPW-1:0]  w_q_nxt;

    assign w_y = r_q[0] ? r_m : '0;

    adder_4b u_add (
        .A    (r_acc),
        .B    (w_y),
        .Cin  (1'b0),
        .S    (w_s),
        .Cout (w_c)
    );

    // {C,S,Q} shifted right by one: the carry lands in ACC[3], S[0] enters Q.
    assign w_acc_nxt = {w_c, w_s[OPW-1:1]};
    assign w_q_nxt   = {w_s[0], r_q[OPW-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_m     <= bus.A;
                        r_acc   <= '0;
                        r_q     <= bus.B;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_p     <= {w_acc_nxt, w_q_nxt};
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.P    = r_p;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: doc/mult_4b_seq.md
# mult_4b_seq

Sequential 4x4 unsigned shift-and-add multiplier that sits directly downstream of the 4-bit ripple adder (`adder_4b`) and consumes its sum and carry on every iteration. It accepts one operand pair on a start pulse and iterates four add/shift steps through a single `adder_4b` instance. It then presents an 8-bit product with a one-cycle `done` strobe. It is the first clocked block built on the combinational adder library.

## Interface
Parameters: none. Width is fixed at 4-bit operands and an 8-bit product.

Ports:
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a multiply. Sampled only in IDLE.
- `A` input 4: multiplicand, unsigned. Captured on the accepted start.
- `B` input 4: multiplier, unsigned. Captured on the accepted start.
- `P` output 8: product register. Holds its last value until the next completion.
- `busy` output 1: high in RUN and DONE. While high, `start` is ignored.
- `done` output 1: one-cycle strobe. `P` is valid and new while it is high.

## Operation
- Reset values: state=IDLE, `P`=8'h00, `busy`=0, `done`=0. Internal M, ACC, Q and CNT are all 0.
- FSM states are IDLE, RUN and DONE.
- **IDLE, `start`=1:**
  - M<=A, ACC<=4'h0, Q<=B, CNT<=0.
  - Next state is RUN.
- **IDLE, `start`=0:** remain in IDLE.
- **RUN, each cycle:**
  - Drive the adder with X=ACC, Y=(Q[0] ? M : 4'h0), Cin=0. This yields {C,S}.
  - Shift right as a 9-bit value {C,S,Q}: ACC<={C,S[3:1]}, Q<={S[0],Q[3:1]}.
  - CNT<=CNT+1.
  - When CNT==3 (fourth iteration), P<={ACC_next,Q_next} and the next state is DONE.
- **DONE:** `done`=1 for exactly one cycle. The next state is IDLE unconditionally.
- **Width rules:**
  - The product never exceeds 8 bits; the maximum is 15*15=225=8'hE1.
  - The adder carry is never dropped. It becomes ACC[3] after the shift.
- **`start` handling:**
  - `start` in RUN or DONE is ignored and not queued.
  - `start` held high continuously produces back-to-back multiplies with one IDLE cycle between them.
- **Operand capture:** A and B may change freely after the accepted start. Only captured values are used.
- **Reset mid-RUN:**
  - Aborts immediately to IDLE. `done` is not pulsed.
  - `P` returns to 8'h00.
- **Zero operands:** A=0 or B=0 still takes the full 4 iterations and yields P=0.

## Timing
- Let E0 be the edge where `start` is sampled in IDLE.
- Iterations occur at edges E1..E4.
- `P` updates at E4. `done` and the new `P` are visible in the cycle after E4.
- `done` drops and `busy` drops at E5.
- Latency from the start-sampling edge to `done` high is 4 cycles. A new start can be accepted at E6 at the earliest.
- `busy` rises after E0 and falls after E5: 5 cycles high.
- The adder path is purely combinational within one cycle. No multicycle paths.

## Structure
- Shared package `mult_pkg`:
  - State enum {IDLE, RUN, DONE}.
  - Constant OPW=4.
  - Constant ITER=4.
  - Product width 2*OPW.
- Sub-module: exactly one `adder_4b` instance. Port map: A=ACC, B=gated M, Cin=1'b0, S, Cout=C.
- No other hierarchy. FSM, datapath registers and counter stay in `mult_4b_seq`.

## Test plan
- Reset, then A=0,B=0,start pulse: `done` after 4 cycles, P=8'h00, `busy` high for 5 cycles.
- A=6,B=5 then A=12,B=10: P=8'h1E, then P=8'h78. `P` holds 8'h1E until the second `done`.
- A=15,B=15: P=8'hE1. Check the carry path through ACC[3].
- Pulse start again at E2 with A=1,B=1 while in RUN, and again in the DONE cycle: both are ignored. Only the original product appears, and exactly one `done` pulse.
- Assert `rst` at E2 of a 15*15 run: IDLE next cycle, P=0, no `done`. A following 3*7 run yields P=8'h15.
- Hold `start`=1 continuously with A=9,B=9: repeated P=8'h51 with `done` every 6 cycles.
